// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter_if
// Brief    : Request/data/grant bundle between four requesters and the
//            round-robin 4:1 arbiter. The master side drives requests and
//            data. The slave side (the arbiter) returns grants and mux output.
// Revision : 1.0 - initial release
// ============================================================================
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       req;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic [WIDTH-1:0] in_d;
    logic [3:0]       gnt;
    logic             sel_a;
    logic             sel_b;
    logic             sel_c;
    logic             sel_d;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;

    modport master (
        output req, in_a, in_b, in_c, in_d,
        input  gnt, sel_a, sel_b, sel_c, sel_d, out, out_valid, busy
    );

    modport slave (
        input  req, in_a, in_b, in_c, in_d,
        output gnt, sel_a, sel_b, sel_c, sel_d, out, out_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter that shares a registered 4:1 data mux among
//            requesters a..d. Each grant is bounded to MAX_HOLD cycles.
//            Define MUX4_ARB_SVA_EN to compile in concurrent assertions.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mux4_rr_arbiter_if.slave   bus
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [0:0]        r_state;
    logic [3:0]        r_gnt;
    logic [1:0]        r_last_owner;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [WIDTH-1:0]  r_out;
    logic              r_out_valid;

    logic [1:0]        w_owner;
    logic [1:0]        w_pick_from;
    logic [1:0]        w_pick_idx;
    logic [3:0]        w_pick_gnt;
    logic              w_release;
    logic              w_any_req;
    logic [WIDTH-1:0]  w_in [4];

    // The first requester after 'owner', in circular order, wins.
    // 'owner' itself is chosen only if no other requester is active.
    function automatic logic [1:0] f_rr_pick(input logic [1:0] owner,
                                             input logic [3:0] req_v);
        logic [1:0] v_idx;
        f_rr_pick = owner;
        for (int i = 3; i >= 1; i--) begin
            v_idx = owner + 2'(i);
            if (req_v[v_idx]) f_rr_pick = v_idx;
        end
    endfunction

    assign w_in[0] = bus.in_a;
    assign w_in[1] = bus.in_b;
    assign w_in[2] = bus.in_c;
    assign w_in[3] = bus.in_d;

    // Encode the current one-hot grant to an owner index.
    always_comb begin
        w_owner = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (r_gnt[k]) w_owner = 2'(k);
        end
    end

    assign w_any_req   = |bus.req;
    assign w_release   = !bus.req[w_owner] || (r_hold_cnt == c_HOLD_LAST);
    assign w_pick_from = (r_state == c_IDLE) ? r_last_owner : w_owner;
    assign w_pick_idx  = f_rr_pick(w_pick_from, bus.req);
    assign w_pick_gnt  = 4'b0001 << w_pick_idx;

    // Arbitration FSM: grant, hold counting, and return to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_gnt        <= 4'b0000;
            r_last_owner <= 2'd3;
            r_hold_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_gnt      <= w_pick_gnt;
                        r_state    <= c_GRANT;
                        r_hold_cnt <= '0;
                    end
                end
                default: begin
                    if (!w_release) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end else if (w_any_req) begin
                        // Hand over directly to the next requester. A forced
                        // release with only the owner requesting re-grants it.
                        r_gnt      <= w_pick_gnt;
                        r_hold_cnt <= '0;
                    end else begin
                        r_gnt        <= 4'b0000;
                        r_last_owner <= w_owner;
                        r_hold_cnt   <= '0;
                        r_state      <= c_IDLE;
                    end
                end
            endcase
        end
    end

    // Registered datapath: capture the granted input one cycle late.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (|r_gnt) begin
            r_out       <= w_in[w_owner];
            r_out_valid <= bus.req[w_owner];
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.sel_a     = r_gnt[0];
    assign bus.sel_b     = r_gnt[1];
    assign bus.sel_c     = r_gnt[2];
    assign bus.sel_d     = r_gnt[3];
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = (r_state == c_GRANT);

`ifdef MUX4_ARB_SVA_EN
    // Sample on the falling edge so the checks never race the posedge updates.
    default clocking cb_sva @(negedge clk);
    endclocking

    a_gnt_onehot0 : assert property ($onehot0(r_gnt));
    a_sel_eq_gnt  : assert property ({bus.sel_d, bus.sel_c, bus.sel_b, bus.sel_a} == r_gnt);
    a_hold_bound  : assert property (r_hold_cnt <= c_HOLD_LAST);
    a_rst_clears  : assert property (rst |=> (r_gnt == 4'b0000 && !r_out_valid));

    for (genvar k = 0; k < 4; k++) begin : g_sva_lane
        a_lane_data : assert property (disable iff (rst)
            (r_gnt[k] && bus.req[k]) |=> (r_out == $past(w_in[k]) && r_out_valid));
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Brief    : Self-checking bench for mux4_rr_arbiter. It drives two instances
//            (MAX_HOLD=8 and MAX_HOLD=2) with shared stimulus and checks both
//            against a cycle-level reference model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din [4];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.WIDTH(4)) bus8 ();
    mux4_rr_arbiter_if #(.WIDTH(4)) bus2 ();

    assign bus8.req  = req;
    assign bus8.in_a = din[0];
    assign bus8.in_b = din[1];
    assign bus8.in_c = din[2];
    assign bus8.in_d = din[3];
    assign bus2.req  = req;
    assign bus2.in_a = din[0];
    assign bus2.in_b = din[1];
    assign bus2.in_c = din[2];
    assign bus2.in_d = din[3];

    mux4_rr_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    mux4_rr_arbiter #(.WIDTH(4), .MAX_HOLD(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    // Reference model: owner index (-1 = none) and number of cycles held.
    int         m_owner [2];
    int         m_held  [2];
    int         m_last  [2];
    logic [3:0] m_out   [2];
    logic       m_ov    [2];
    int         m_max   [2] = '{8, 2};

    function automatic int pick(input int p, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return p;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_owner[d] = -1; m_last[d] = 3; m_held[d] = 0;
                m_out[d] = 4'd0; m_ov[d] = 1'b0;
            end else begin
                if (m_owner[d] >= 0) begin
                    m_out[d] = din[m_owner[d]];
                    m_ov[d]  = req[m_owner[d]];
                end else begin
                    m_ov[d] = 1'b0;
                end
                if (m_owner[d] < 0) begin
                    if (req != 4'd0) begin
                        m_owner[d] = pick(m_last[d], req);
                        m_held[d]  = 1;
                    end
                end else if (req[m_owner[d]] && m_held[d] < m_max[d]) begin
                    m_held[d]++;
                end else if (req != 4'd0) begin
                    m_owner[d] = pick(m_owner[d], req);
                    m_held[d]  = 1;
                end else begin
                    m_last[d]  = m_owner[d];
                    m_owner[d] = -1;
                    m_held[d]  = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int d, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s dut%0d cycle %0d got %0h expected %0h", name, d, cyc, got, exp);
        end
    endtask

    task automatic model_cmp(input int d, input logic [3:0] gnt, input logic [3:0] sel,
                             input logic [3:0] out, input logic ov, input logic busy);
        logic [3:0] eg;
        eg = (m_owner[d] < 0) ? 4'd0 : (4'b0001 << m_owner[d]);
        chk("model_gnt", d, gnt, eg);
        chk("model_sel", d, sel, eg);
        chk("model_out", d, out, m_out[d]);
        chk("model_out_valid", d, ov, m_ov[d]);
        chk("model_busy", d, busy, (m_owner[d] >= 0));
    endtask

    // One clock: model advances with the edge, both DUTs are checked at negedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        model_cmp(0, bus8.gnt, {bus8.sel_d, bus8.sel_c, bus8.sel_b, bus8.sel_a},
                  bus8.out, bus8.out_valid, bus8.busy);
        model_cmp(1, bus2.gnt, {bus2.sel_d, bus2.sel_c, bus2.sel_b, bus2.sel_a},
                  bus2.out, bus2.out_valid, bus2.busy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'd0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("rst_gnt", 0, bus8.gnt, 0);
            chk("rst_out", 0, bus8.out, 0);
            chk("rst_out_valid", 0, bus8.out_valid, 0);
            chk("rst_busy", 0, bus8.busy, 0);
        end
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] exp_gnt;
        logic [3:0] exp_out;
        logic       exp_ov;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Directed vectors for the MAX_HOLD=8 instance, inputs a..d = 1..4.
        tbl[0]  = '{1'b0, 4'b0010, 4'b0010, 4'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 4'b0010, 4'b0010, 4'd2, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 4'b0010, 4'b0010, 4'd2, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 4'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 4'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'b1111, 4'b0100, 4'd2, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 4'b1111, 4'b0100, 4'd3, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 4'b1111, 4'b0000, 4'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b1111, 4'b0001, 4'd0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 4'b1111, 4'b0001, 4'd1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 4'b1110, 4'b0010, 4'd1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 4'b1110, 4'b0010, 4'd2, 1'b1, 1'b1};

        rst = 1'b1;
        req = 4'd0;
        din = '{4'd1, 4'd2, 4'd3, 4'd4};
        do_reset();

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            cycle();
            chk("tbl_gnt", 0, bus8.gnt, tbl[i].exp_gnt);
            chk("tbl_out", 0, bus8.out, tbl[i].exp_out);
            chk("tbl_out_valid", 0, bus8.out_valid, tbl[i].exp_ov);
            chk("tbl_busy", 0, bus8.busy, tbl[i].exp_busy);
        end

        // a and c alternate every 8 forced-release cycles, data one cycle late.
        do_reset();
        din = '{4'd3, 4'd0, 4'd9, 4'd0};
        req = 4'b0101;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            chk("alt_gnt", 0, bus8.gnt, ((((k - 1) / 8) % 2) == 0) ? 4'b0001 : 4'b0100);
            if (k == 1) begin
                chk("alt_out_valid", 0, bus8.out_valid, 0);
            end else begin
                chk("alt_out", 0, bus8.out, ((((k - 2) / 8) % 2) == 0) ? 3 : 9);
                chk("alt_out_valid", 0, bus8.out_valid, 1);
            end
        end

        // All requesting with MAX_HOLD=2: a,a,b,b,c,c,d,d,a,a with no bubble.
        do_reset();
        req = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            chk("rr2_gnt", 1, bus2.gnt, 4'b0001 << (((k - 1) / 2) % 4));
            chk("rr2_busy", 1, bus2.busy, 1);
        end

        // A lone requester d is re-granted across forced releases, never dropped.
        do_reset();
        req = 4'b1000;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            chk("solo_gnt8", 0, bus8.gnt, 4'b1000);
            chk("solo_gnt2", 1, bus2.gnt, 4'b1000);
        end

        // Randomized traffic with sticky requests and occasional resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            for (int j = 0; j < 4; j++) din[j] = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
